syn_branch_predictor: RTL and testbench
=======================================

SYN_BRANCH_PREDICTOR -- requirements
Module: syn_branch_predictor

Interface
REQ-001 Parameter ADDR_BIT, default 10: width of the word-address PC. Equals the instruction-memory address width.
REQ-002 Parameter ENTRIES, default 16: number of table entries; power of two, 2..256. IDX_BIT = log2(ENTRIES); TAG_BIT = ADDR_BIT - IDX_BIT.
REQ-003 Parameter CNT_BIT, default 2: width of the saturating counter, 1..3.
REQ-004 Parameter MODE, default 1: 0 = static not-taken, 1 = dynamic counter prediction.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port en, input, 1: global enable; when low, no state changes.
REQ-008 Port lookup_pc, input, ADDR_BIT: PC of the fetch-stage instruction.
REQ-009 Port pred_hit, output, 1: lookup_pc matches a valid entry.
REQ-010 Port pred_taken, output, 1: predicted taken.
REQ-011 Port pred_addr, output, ADDR_BIT: predicted next PC.
REQ-012 Port upd_valid, input, 1: a resolved branch or jump from the execute stage.
REQ-013 Port upd_pc, input, ADDR_BIT: PC of the resolved instruction.
REQ-014 Port upd_taken, input, 1: the resolved instruction was taken.
REQ-015 Port upd_target, input, ADDR_BIT: resolved taken target.
REQ-016 Port upd_mispredict, input, 1: the earlier prediction for this instruction was wrong.
REQ-017 Port flush, input, 1: invalidate all entries.
REQ-018 Port stat_branches, output, 32: count of resolved updates.
REQ-019 Port stat_mispredicts, output, 32: count of mispredictions.

Function
REQ-020 Each entry SHALL hold: valid (1), tag (TAG_BIT), target (ADDR_BIT), cnt (CNT_BIT).
- Index = pc[IDX_BIT-1:0].
- Tag = pc[ADDR_BIT-1:IDX_BIT].
REQ-021 Lookup SHALL be combinational from registered state, with zero-cycle latency.
- pred_hit = valid && tag match.
REQ-022 pred_taken SHALL be computed as follows:
- MODE 1: pred_taken = pred_hit && cnt MSB.
- MODE 0: pred_taken = 0.
REQ-023 pred_addr SHALL be target when pred_taken, else (lookup_pc + 1) mod 2^ADDR_BIT.
REQ-024 Update SHALL occur on a rising edge with en && upd_valid && !flush, on the entry at upd_pc's index. It becomes visible to lookup the next cycle; there is no same-cycle bypass.
REQ-025 Update on a hit SHALL adjust cnt and target:
- upd_taken: cnt = min(cnt+1, 2^CNT_BIT-1) and target = upd_target.
- Not taken: cnt = max(cnt-1, 0) and target unchanged.
REQ-026 Update on a miss SHALL depend on upd_taken:
- upd_taken: allocate or replace the entry: valid=1, tag, target = upd_target, cnt = 2^(CNT_BIT-1) (weakly taken).
- Not taken: no table change.
REQ-027 In MODE 0, the table SHALL still be updated and the stats SHALL still count; only the prediction outputs are forced per REQ-022/023.
REQ-028 When en && upd_valid, stat_branches SHALL increment by 1, saturating at 0xFFFFFFFF.
REQ-029 When en && upd_valid && upd_mispredict, stat_mispredicts SHALL increment by 1, saturating at 0xFFFFFFFF. upd_mispredict without upd_valid SHALL be ignored.
REQ-030 flush with en SHALL clear all valid bits at the next edge and leave stats unchanged.
- flush and upd_valid in the same cycle: flush wins for the table; stats still count the update.
REQ-031 While en=0, all inputs except rst SHALL be ignored; outputs continue to reflect the held state.

Reset
REQ-032 rst SHALL take priority over en, flush and upd_valid.
REQ-033 On rst, all fields SHALL clear at the next edge: valid=0, tag=0, target=0, cnt=0, stat_branches=0, stat_mispredicts=0.
REQ-034 After reset, outputs SHALL be pred_hit=0, pred_taken=0, pred_addr=lookup_pc+1.
REQ-035 rst asserted mid-operation SHALL discard any coincident update.

Verification (defaults: ADDR_BIT=10, ENTRIES=16, CNT_BIT=2, MODE=1)
REQ-036 Reset, then lookup_pc=0x004 -> pred_hit=0, pred_taken=0, pred_addr=0x005. lookup_pc=0x3FF -> pred_addr=0x000 (wrap).
REQ-037 Update pc=0x004, taken, target=0x040 -> next cycle, lookup 0x004 gives pred_hit=1, pred_taken=1, pred_addr=0x040 (cnt=2).
- Two more taken updates -> cnt=3 and holds.
- Then two not-taken updates -> cnt=1, pred_taken=0, pred_addr=0x005.
- A third not-taken update -> cnt=0, and it holds at 0 on a fourth.
REQ-038 With entry 0x004 valid, lookup 0x014 (same index, different tag) -> pred_hit=0.
- Not-taken update at 0x014 -> 0x004 is still hit.
- Taken update at 0x014, target 0x100 -> 0x004 misses; 0x014 hits with pred_addr=0x100.
REQ-039 Assert flush together with a taken update at 0x008 -> all lookups miss the next cycle; stat_branches has incremented by 1.
- Same update with en=0 -> no table or stats change.
REQ-040 Five updates, two with upd_mispredict=1, then rst mid-sequence with a coincident update:
- Before rst: stat_branches=5, stat_mispredicts=2.
- After rst: both stats=0 and the coincident entry is not allocated.
REQ-041 MODE=0 instance, taken update at 0x004 -> lookup gives pred_hit=1, pred_taken=0, pred_addr=0x005.

Source files
------------

// File: rtl/syn_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational from the table; updates, flushes and stats are registered.
module syn_bp_entry #(
  parameter int ADDR_BIT = 10,
  parameter int TAG_BIT  = 6,
  parameter int CNT_BIT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr,
  input  logic [TAG_BIT-1:0]  upd_tag,
  input  logic                upd_taken,
  input  logic [ADDR_BIT-1:0] upd_target,
  output logic                valid,
  output logic [TAG_BIT-1:0]  tag,
  output logic [ADDR_BIT-1:0] target,
  output logic [CNT_BIT-1:0]  cnt
);
  localparam logic [CNT_BIT-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BIT-1:0] CNT_WEAK = CNT_BIT'(1 << (CNT_BIT-1));

  logic hit;
  assign hit = valid && (tag == upd_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      cnt    <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      if (hit) begin
        if (upd_taken) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          target <= upd_target;
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch replaces whatever lived at this index.
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        cnt    <= CNT_WEAK;
      end
    end
  end
endmodule

module syn_branch_predictor #(
  parameter int ADDR_BIT = 10,
  parameter int ENTRIES  = 16,
  parameter int CNT_BIT  = 2,
  parameter int MODE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ADDR_BIT-1:0] lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [ADDR_BIT-1:0] pred_addr,
  input  logic                upd_valid,
  input  logic [ADDR_BIT-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_BIT-1:0] upd_target,
  input  logic                upd_mispredict,
  input  logic                flush,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);
  localparam int IDX_BIT = $clog2(ENTRIES);
  localparam int TAG_BIT = ADDR_BIT - IDX_BIT;

  logic [ENTRIES-1:0]               e_valid;
  logic [ENTRIES-1:0][TAG_BIT-1:0]  e_tag;
  logic [ENTRIES-1:0][ADDR_BIT-1:0] e_target;
  logic [ENTRIES-1:0][CNT_BIT-1:0]  e_cnt;

  logic [IDX_BIT-1:0] upd_idx, lk_idx;
  logic [TAG_BIT-1:0] upd_tag, lk_tag;
  logic               upd_go;

  assign upd_idx = upd_pc[IDX_BIT-1:0];
  assign upd_tag = upd_pc[ADDR_BIT-1:IDX_BIT];
  assign lk_idx  = lookup_pc[IDX_BIT-1:0];
  assign lk_tag  = lookup_pc[ADDR_BIT-1:IDX_BIT];
  assign upd_go  = en && upd_valid && !flush;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    syn_bp_entry #(.ADDR_BIT(ADDR_BIT), .TAG_BIT(TAG_BIT), .CNT_BIT(CNT_BIT)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .clr        (en && flush),
      .wr         (upd_go && (upd_idx == IDX_BIT'(g))),
      .upd_tag    (upd_tag),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .valid      (e_valid[g]),
      .tag        (e_tag[g]),
      .target     (e_target[g]),
      .cnt        (e_cnt[g])
    );
  end

  assign pred_hit   = e_valid[lk_idx] && (e_tag[lk_idx] == lk_tag);
  assign pred_taken = (MODE != 0) && pred_hit && e_cnt[lk_idx][CNT_BIT-1];
  assign pred_addr  = pred_taken ? e_target[lk_idx] : lookup_pc + 1'b1;

  // Stats count every resolved update, even one a flush kept out of the table.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (en && upd_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (upd_mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
endmodule

// File: tb/tb_syn_branch_predictor.sv
// Scoreboard bench: a table model predicts outputs of a MODE=1 and a MODE=0 instance.
module tb_syn_branch_predictor;
  logic       clk = 0;
  logic       rst, en, upd_valid, upd_taken, upd_mispredict, flush;
  logic [9:0] lookup_pc, upd_pc, upd_target;
  logic       hit1, tk1, hit0, tk0;
  logic [9:0] addr1, addr0;
  logic [31:0] br1, mp1, br0, mp0;

  always #5 clk = ~clk;

  syn_branch_predictor #(.ADDR_BIT(10), .ENTRIES(16), .CNT_BIT(2), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .lookup_pc(lookup_pc),
    .pred_hit(hit1), .pred_taken(tk1), .pred_addr(addr1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .flush(flush),
    .stat_branches(br1), .stat_mispredicts(mp1));

  syn_branch_predictor #(.ADDR_BIT(10), .ENTRIES(16), .CNT_BIT(2), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .lookup_pc(lookup_pc),
    .pred_hit(hit0), .pred_taken(tk0), .pred_addr(addr0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .flush(flush),
    .stat_branches(br0), .stat_mispredicts(mp0));

  typedef struct packed {
    logic       hit, taken;
    logic [9:0] addr;
    logic [31:0] br, mp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  // Reference table: plain integers, indexed by pc mod 16, tag = pc / 16.
  bit        m_v[16];
  int        m_tag[16], m_tgt[16], m_cnt[16];
  longint    m_br, m_mp;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("m1_hit",   hit1,  e.hit);
      chk("m1_taken", tk1,   e.taken);
      chk("m1_addr",  addr1, e.addr);
      chk("m1_br",    br1,   e.br);
      chk("m1_mp",    mp1,   e.mp);
      chk("m0_hit",   hit0,  e.hit);
      chk("m0_taken", tk0,   1'b0);
      chk("m0_addr",  addr0, 10'((lookup_pc + 1) % 1024));
      chk("m0_br",    br0,   e.br);
      chk("m0_mp",    mp0,   e.mp);
    end
  end

  function automatic exp_t predict(int pc);
    exp_t e;
    int i = pc % 16;
    e.hit   = m_v[i] && m_tag[i] == pc / 16;
    e.taken = e.hit && m_cnt[i] >= 2;
    e.addr  = e.taken ? 10'(m_tgt[i]) : 10'((pc + 1) % 1024);
    e.br    = 32'(m_br);
    e.mp    = 32'(m_mp);
    return e;
  endfunction

  task automatic model_edge(bit r, bit e, bit uv, int upc, bit ut, int utg, bit um, bit fl);
    int i = upc % 16;
    if (r) begin
      for (int k = 0; k < 16; k++) begin m_v[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0; end
      m_br = 0; m_mp = 0;
    end else if (e) begin
      if (uv) begin
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (um && m_mp < 64'hFFFF_FFFF) m_mp++;
      end
      if (fl) begin
        for (int k = 0; k < 16; k++) m_v[k] = 0;
      end else if (uv) begin
        if (m_v[i] && m_tag[i] == upc / 16) begin
          if (ut) begin m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3; m_tgt[i] = utg; end
          else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end else if (ut) begin
          m_v[i] = 1; m_tag[i] = upc / 16; m_tgt[i] = utg; m_cnt[i] = 2;
        end
      end
    end
  endtask

  // Called just after a rising edge: drive, queue expectation, cross the next edge.
  task automatic cyc(bit r, bit e, int lpc, bit uv, int upc, bit ut, int utg, bit um, bit fl, bit push = 1);
    rst = r; en = e; lookup_pc = 10'(lpc); upd_valid = uv; upd_pc = 10'(upc);
    upd_taken = ut; upd_target = 10'(utg); upd_mispredict = um; flush = fl;
    if (push) q.push_back(predict(lpc));
    @(posedge clk);
    model_edge(r, e, uv, upc, ut, utg, um, fl);
    #1;
  endtask

  task automatic look(int pc);
    cyc(0, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(int pc, bit t, int tgt, bit mis = 0);
    cyc(0, 1, pc, 1, pc, t, tgt, mis, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 4, 1, 5, 1, 1, 0);
    // reset state, wrap of fall-through address
    look('h004); look('h3FF);
    // counter climb, saturate, descend, floor
    upd('h004, 1, 'h040); look('h004);
    upd('h004, 1, 'h040); upd('h004, 1, 'h040); look('h004);
    upd('h004, 0, 0); upd('h004, 0, 0); look('h004);
    upd('h004, 0, 0); upd('h004, 0, 0); look('h004);
    // aliasing at the same index
    upd('h004, 1, 'h040); upd('h004, 1, 'h040);
    look('h014); upd('h014, 0, 0); look('h004);
    upd('h014, 1, 'h100); look('h004); look('h014);
    // flush vs update, and disabled cycles
    cyc(0, 1, 'h008, 1, 'h008, 1, 'h200, 0, 1); look('h008); look('h014);
    cyc(0, 0, 'h008, 1, 'h008, 1, 'h200, 1, 0); look('h008);
    cyc(0, 0, 'h008, 0, 0, 0, 0, 0, 1); look('h008);
    // stats, then reset with a coincident update
    upd('h020, 1, 'h050, 1); upd('h021, 1, 'h051); upd('h022, 1, 'h052, 1);
    upd('h020, 0, 0); cyc(0, 1, 'h021, 0, 'h3, 0, 0, 1, 0); upd('h023, 0, 0);
    look('h020);
    cyc(1, 1, 'h030, 1, 'h030, 1, 'h077, 1, 0); look('h030); look('h020);
    // randomized traffic over a small tag pool so entries get reused
    for (int n = 0; n < 3000; n++) begin
      int lpc = ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      int upc = ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) lpc = $urandom_range(0, 1023);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, lpc,
          $urandom_range(0, 1), upc, $urandom_range(0, 2) != 0, $urandom_range(0, 1023),
          $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
    end
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
